tff_pulse_driver: RTL and testbench



---
 rtl/tff_pulse_driver.sv | 187 ++++++++++++++++++
 tb/tb_tff_pulse_driver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tff_pulse_driver.sv
// tff_pulse_driver: stimulus/readout engine for a toggle-flip-flop cell.
//
// Accepts a pulse count on a valid/ready command port, clears the TFF, issues exactly
// that many write-enable pulses, asserts read-enable, samples the cell's out/carry and
// returns the result on a valid/ready response port. Every output is a flop.
//
// Ports:
//   clk        system clock, rising edge
//   rstb       asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  driver can accept a command
//   cmd_count  number of WE pulses to issue
//   rsp_valid  result available
//   rsp_ready  consumer accepts result
//   rsp_out    tff_out sampled on the last read cycle
//   rsp_carry  sticky OR of tff_carry over pulse and read phases
//   tff_we     write-enable pulse to the TFF
//   tff_re     read-enable to the TFF
//   tff_rstb   active-low clear to the TFF
//   tff_out    TFF state
//   tff_carry  TFF carry
//   rsp_err    (only with TFF_PULSE_DRIVER_CHECK_EN) rsp_out differs from the parity of
//              cmd_count; meaningful only while rsp_valid is high
//
// Optional feature macro: TFF_PULSE_DRIVER_CHECK_EN adds rsp_err and its compare logic.

module tff_pulse_driver #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 2,
    parameter int unsigned CLR_W   = 2,
    parameter int unsigned READ_W  = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_out,
    output logic             rsp_carry,
    output logic             tff_we,
    output logic             tff_re,
    output logic             tff_rstb,
    input  logic             tff_out,
    input  logic             tff_carry
`ifdef TFF_PULSE_DRIVER_CHECK_EN
    ,
    output logic             rsp_err
`endif
);

    // The clear phase holds tff_rstb low for CLR_W cycles and then spends one more
    // cycle with tff_rstb released, so the first WE/RE edge never coincides with the
    // release of the clear.
    localparam int unsigned ClrLen = CLR_W + 1;
    localparam int unsigned MaxA   = (ClrLen > PULSE_W) ? ClrLen : PULSE_W;
    localparam int unsigned MaxB   = (GAP_W > READ_W) ? GAP_W : READ_W;
    localparam int unsigned MaxLen = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CYC_W  = $clog2(MaxLen + 1);

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StPulseHi,
        StPulseLo,
        StRead,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               acc_q, acc_d;
    logic               rsp_out_d, rsp_carry_d;
`ifdef TFF_PULSE_DRIVER_CHECK_EN
    logic               par_q, par_d;
    logic               rsp_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        rsp_out_d   = rsp_out;
        rsp_carry_d = rsp_carry;
`ifdef TFF_PULSE_DRIVER_CHECK_EN
        par_d       = par_q;
        rsp_err_d   = rsp_err;
`endif
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    rem_d   = cmd_count;
                    acc_d   = 1'b0;
`ifdef TFF_PULSE_DRIVER_CHECK_EN
                    par_d   = cmd_count[0];
`endif
                    state_d = StClr;
                end
            end
            StClr: begin
                if (cyc_q == CYC_W'(ClrLen - 1)) begin
                    state_d = (rem_q != '0) ? StPulseHi : StRead;
                end
            end
            StPulseHi: begin
                acc_d = acc_q | tff_carry;
                if (cyc_q == CYC_W'(PULSE_W - 1)) begin
                    state_d = StPulseLo;
                end
            end
            StPulseLo: begin
                acc_d = acc_q | tff_carry;
                if (cyc_q == CYC_W'(GAP_W - 1)) begin
                    // rem_q is never zero here, so the decrement cannot wrap.
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == CNT_W'(1)) ? StRead : StPulseHi;
                end
            end
            StRead: begin
                acc_d = acc_q | tff_carry;
                if (cyc_q == CYC_W'(READ_W - 1)) begin
                    rsp_out_d   = tff_out;
                    rsp_carry_d = acc_q | tff_carry;
`ifdef TFF_PULSE_DRIVER_CHECK_EN
                    rsp_err_d   = tff_out ^ par_q;
`endif
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (rsp_valid && rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Cycle counter restarts on every state change and idles at zero when untimed.
        if (state_d != state_q || state_q == StIdle || state_q == StDone) begin
            cyc_d = '0;
        end else begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= StIdle;
            cyc_q     <= '0;
            rem_q     <= '0;
            acc_q     <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_out   <= 1'b0;
            rsp_carry <= 1'b0;
            tff_we    <= 1'b0;
            tff_re    <= 1'b0;
            tff_rstb  <= 1'b0;
`ifdef TFF_PULSE_DRIVER_CHECK_EN
            par_q     <= 1'b0;
            rsp_err   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            rem_q     <= rem_d;
            acc_q     <= acc_d;
            // Outputs are decoded from the next state so they change on the same edge
            // as the state itself.
            cmd_ready <= (state_d == StIdle);
            rsp_valid <= (state_d == StDone);
            rsp_out   <= rsp_out_d;
            rsp_carry <= rsp_carry_d;
            tff_we    <= (state_d == StPulseHi);
            tff_re    <= (state_d == StRead);
            tff_rstb  <= !((state_d == StClr) && (cyc_d < CYC_W'(CLR_W)));
`ifdef TFF_PULSE_DRIVER_CHECK_EN
            par_q     <= par_d;
            rsp_err   <= rsp_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_tff_pulse_driver.sv
// Directed bench for tff_pulse_driver with an ideal toggle-cell model on the TFF side.
module tb_tff_pulse_driver;

    logic       clk = 1'b0;
    logic       rstb = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_count = 8'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_out;
    logic       rsp_carry;
    logic       tff_we;
    logic       tff_re;
    logic       tff_rstb;
    logic       tff_out;
    logic       tff_carry;
`ifdef TFF_PULSE_DRIVER_CHECK_EN
    logic       rsp_err;
`endif

    int vectors = 0;
    int miscompares = 0;

    tff_pulse_driver dut (
        .clk       (clk),
        .rstb      (rstb),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_count (cmd_count),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_carry (rsp_carry),
        .tff_we    (tff_we),
        .tff_re    (tff_re),
        .tff_rstb  (tff_rstb),
        .tff_out   (tff_out),
        .tff_carry (tff_carry)
`ifdef TFF_PULSE_DRIVER_CHECK_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    always #5 clk = ~clk;

    // Ideal toggle cell: flips on each WE rising edge, carry set when it wraps 1->0.
    logic m_q = 1'b0;
    logic m_carry = 1'b0;
    logic stuck = 1'b0;
    always @(posedge tff_we or negedge tff_rstb) begin
        if (!tff_rstb) begin
            m_q     <= 1'b0;
            m_carry <= 1'b0;
        end else begin
            m_carry <= m_q;
            m_q     <= ~m_q;
        end
    end
    assign tff_out   = stuck ? 1'b0 : m_q;
    assign tff_carry = stuck ? 1'b0 : m_carry;

    // Free-running monitors; tests take differences of snapshots.
    int we_edges = 0;
    int we_hi = 0;
    int re_hi = 0;
    int clr_lo = 0;
    int viol = 0;
    always @(posedge tff_we) we_edges <= we_edges + 1;
    always @(posedge clk) begin
        if (tff_we) we_hi <= we_hi + 1;
        if (tff_re) re_hi <= re_hi + 1;
        if (!tff_rstb) clr_lo <= clr_lo + 1;
        if ((tff_we && tff_re) || (!tff_rstb && (tff_we || tff_re))) viol <= viol + 1;
    end

    int b_we_edges, b_we_hi, b_re_hi, b_clr_lo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; the handshake happens on the next edge.
    task automatic issue(input logic [7:0] n);
        b_we_edges = we_edges;
        b_we_hi    = we_hi;
        b_re_hi    = re_hi;
        b_clr_lo   = clr_lo;
        cmd_count  = n;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (lat < 200 && !rsp_valid) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic rsp_handshake(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_rsp_valid_drop"}, rsp_valid, 0);
        chk({tag, "_cmd_ready_back"}, cmd_ready, 1);
    endtask

    initial begin
        int lat;
        int seen;

        // Reset
        #3 rstb = 1'b0;
        #1;
        chk("rst_tff_rstb", tff_rstb, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_tff_we", tff_we, 0);
        chk("rst_tff_re", tff_re, 0);
        chk("rst_rsp_out", rsp_out, 0);
        chk("rst_rsp_carry", rsp_carry, 0);
        repeat (2) @(posedge clk);
        #1;
        rstb = 1'b1;
        #1;
        chk("rel_pre_edge_cmd_ready", cmd_ready, 0);
        @(posedge clk);
        #1;
        chk("rel_cmd_ready", cmd_ready, 1);
        chk("rel_tff_rstb", tff_rstb, 1);
        chk("rel_tff_we", tff_we, 0);
        chk("rel_tff_re", tff_re, 0);
        chk("rel_rsp_valid", rsp_valid, 0);

        // Three pulses
        issue(8'd3);
        chk("n3_cmd_ready_drop", cmd_ready, 0);
        chk("n3_clear_low", tff_rstb, 0);
        wait_rsp(lat);
        chk("n3_latency", lat, 19);
        chk("n3_we_edges", we_edges - b_we_edges, 3);
        chk("n3_we_hi_cycles", we_hi - b_we_hi, 6);
        chk("n3_re_cycles", re_hi - b_re_hi, 4);
        chk("n3_clr_cycles", clr_lo - b_clr_lo, 2);
        chk("n3_rsp_out", rsp_out, 1);
        chk("n3_rsp_carry", rsp_carry, 1);
`ifdef TFF_PULSE_DRIVER_CHECK_EN
        chk("n3_rsp_err", rsp_err, 0);
`endif
        rsp_handshake("n3");

        // Zero pulses
        issue(8'd0);
        wait_rsp(lat);
        chk("n0_latency", lat, 7);
        chk("n0_we_edges", we_edges - b_we_edges, 0);
        chk("n0_re_cycles", re_hi - b_re_hi, 4);
        chk("n0_clr_cycles", clr_lo - b_clr_lo, 2);
        chk("n0_rsp_out", rsp_out, 0);
        chk("n0_rsp_carry", rsp_carry, 0);
        rsp_handshake("n0");

        // Two pulses, stray commands mid-operation, long backpressure
        issue(8'd2);
        cmd_count = 8'hAA;
        cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_rsp(lat);
        chk("n2_latency", lat + 3, 15);
        chk("n2_we_edges", we_edges - b_we_edges, 2);
        for (int i = 0; i < 10; i++) begin
            cmd_valid = i[0];
            @(posedge clk);
            #1;
            chk("n2_hold_rsp_valid", rsp_valid, 1);
            chk("n2_hold_rsp_out", rsp_out, 0);
            chk("n2_hold_rsp_carry", rsp_carry, 1);
            chk("n2_hold_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        rsp_handshake("n2");
        b_we_edges = we_edges;
        b_clr_lo = clr_lo;
        repeat (4) @(posedge clk);
        #1;
        chk("n2_no_stray_clear", clr_lo - b_clr_lo, 0);
        chk("n2_no_stray_pulse", we_edges - b_we_edges, 0);

        // Reset during the second pulse of a five-pulse command
        issue(8'd5);
        seen = 0;
        while (seen < 60 && (we_edges - b_we_edges) < 2) begin
            @(posedge clk);
            #1;
            seen++;
        end
        chk("mid_second_pulse_seen", we_edges - b_we_edges, 2);
        chk("mid_we_high", tff_we, 1);
        rstb = 1'b0;
        #1;
        chk("mid_rst_tff_we", tff_we, 0);
        chk("mid_rst_tff_rstb", tff_rstb, 0);
        chk("mid_rst_tff_re", tff_re, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        rstb = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rel_cmd_ready", cmd_ready, 1);
        chk("mid_rel_tff_rstb", tff_rstb, 1);
        issue(8'd1);
        wait_rsp(lat);
        chk("n1_latency", lat, 11);
        chk("n1_we_edges", we_edges - b_we_edges, 1);
        chk("n1_rsp_out", rsp_out, 1);
        chk("n1_rsp_carry", rsp_carry, 0);
`ifdef TFF_PULSE_DRIVER_CHECK_EN
        chk("n1_rsp_err", rsp_err, 0);
`endif
        rsp_handshake("n1");

        // Cell stuck at zero
        stuck = 1'b1;
        issue(8'd1);
        wait_rsp(lat);
        chk("stuck_latency", lat, 11);
        chk("stuck_rsp_out", rsp_out, 0);
`ifdef TFF_PULSE_DRIVER_CHECK_EN
        chk("stuck_rsp_err", rsp_err, 1);
`endif
        rsp_handshake("stuck");
        stuck = 1'b0;

        chk("enable_overlap_violations", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
